// File: rtl/status_vector_pkg.sv
// Shared types and helpers for the status_vector_ctrl front-end.
// Holds the drain-state encoding and the occupancy-counter width function.
package status_vector_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/status_vector_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i, with wrap.
// Returns a one-hot grant, the winner index and a valid flag.
module status_vector_rr_arb
    import status_vector_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    logic          found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (32'(ptr_i) + 32'(k)) % 32'(N);
            cand_idx = IW'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/status_vector_ctrl.sv
// Front-end controller for one status_value_vector: round-robin push arbitration, pull/set
// qualification, local occupancy tracking and a drain FSM. Optional checker: STATUS_VECTOR_CTRL_CHECK_EN.
module status_vector_ctrl
    import status_vector_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            push_req_i,
    input  logic [NUM_REQ*WIDTH-1:0]      push_data_i,
    output logic [NUM_REQ-1:0]            push_ack_o,
    input  logic [NUM_REQ-1:0]            set_req_i,
    input  logic [NUM_REQ*WIDTH-1:0]      set_data_i,
    output logic [NUM_REQ-1:0]            set_ack_o,
    input  logic                          pull_req_i,
    output logic                          pull_ack_o,
    input  logic                          drain_i,
    output logic                          drain_done_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          svv_push_o,
    output logic                          svv_pull_o,
    output logic                          svv_set_o,
    output logic [WIDTH-1:0]              svv_value_o,
    output logic [WIDTH-1:0]              svv_set_value_o
`ifdef STATUS_VECTOR_CTRL_CHECK_EN
    ,
    input  logic                          svv_valid_i,
    input  logic                          svv_full_i,
    output logic                          mismatch_o
`endif
);

    localparam int CW = count_width(DEPTH);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    drain_state_t       state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      owner_q;
    logic               owner_valid_q;

    logic [NUM_REQ-1:0] win_grant;
    logic [IW-1:0]      win_idx;
    logic               win_valid;
    logic               pull_acc;
    logic               push_ok;
    logic               push_acc;
    logic               set_acc;

    status_vector_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i   (push_req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Acks are gated by rst_i so every output reads 0 while reset is held.
    assign pull_acc = !rst_i && pull_req_i && (count_q != '0);
    assign push_ok  = !rst_i && (state_q == RUN) && ((count_q < DEPTH_C) || pull_acc);
    assign push_acc = push_ok && win_valid;
    assign set_acc  = !rst_i && owner_valid_q && set_req_i[owner_q] && !push_acc
                      && (count_q != '0) && !(pull_acc && (count_q == CW'(1)));

    always_comb begin
        set_ack_o = '0;
        if (set_acc) begin
            set_ack_o[owner_q] = 1'b1;
        end
    end

    assign push_ack_o   = push_acc ? win_grant : '0;
    assign pull_ack_o   = pull_acc;
    assign count_o      = count_q;
    assign drain_done_o = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_i) state_d = DRAIN;
            DRAIN:   if (!drain_i) state_d = RUN;
                     else if (count_q == '0) state_d = DONE;
            DONE:    if (!drain_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= RUN;
            count_q         <= '0;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            owner_valid_q   <= 1'b0;
            svv_push_o      <= 1'b0;
            svv_pull_o      <= 1'b0;
            svv_set_o       <= 1'b0;
            svv_value_o     <= '0;
            svv_set_value_o <= '0;
        end else begin
            state_q    <= state_d;
            svv_push_o <= push_acc;
            svv_pull_o <= pull_acc;
            svv_set_o  <= set_acc;

            if (push_acc && !pull_acc) begin
                count_q <= count_q + CW'(1);
            end else if (pull_acc && !push_acc) begin
                count_q <= count_q - CW'(1);
            end

            if (push_acc) begin
                rr_ptr_q      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                owner_q       <= win_idx;
                owner_valid_q <= 1'b1;
                svv_value_o   <= push_data_i[win_idx*WIDTH +: WIDTH];
            end else if (pull_acc && (count_q == CW'(1))) begin
                owner_valid_q <= 1'b0;
            end

            if (set_acc) begin
                svv_set_value_o <= set_data_i[owner_q*WIDTH +: WIDTH];
            end
        end
    end

`ifdef STATUS_VECTOR_CTRL_CHECK_EN
    // The vector applies a strobe one edge after the count changes, so compare against count_q delayed.
    logic [CW-1:0] count_d1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_d1_q <= '0;
            mismatch_o <= 1'b0;
        end else begin
            count_d1_q <= count_q;
            if ((svv_valid_i != (count_d1_q != '0)) || (svv_full_i != (count_d1_q == DEPTH_C))) begin
                mismatch_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_status_vector_ctrl.sv
// Self-checking bench for status_vector_ctrl: directed phases plus random traffic,
// checked cycle by cycle against an occupancy/owner/pointer reference model.
module tb_status_vector_ctrl;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 64;
    localparam int WIDTH   = 8;
    localparam int CW      = $clog2(DEPTH + 1);

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NUM_REQ-1:0]       push_req;
    logic [NUM_REQ*WIDTH-1:0] push_data;
    logic [NUM_REQ-1:0]       push_ack;
    logic [NUM_REQ-1:0]       set_req;
    logic [NUM_REQ*WIDTH-1:0] set_data;
    logic [NUM_REQ-1:0]       set_ack;
    logic                     pull_req;
    logic                     pull_ack;
    logic                     drain;
    logic                     drain_done;
    logic [CW-1:0]            count;
    logic                     svv_push, svv_pull, svv_set;
    logic [WIDTH-1:0]         svv_value, svv_set_value;
`ifdef STATUS_VECTOR_CTRL_CHECK_EN
    logic                     svv_valid = 1'b0;
    logic                     svv_full  = 1'b0;
    logic                     mismatch;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy, pointer, owner and drain mode (0 run, 1 draining, 2 done).
    int m_count, m_count_d1, m_ptr, m_owner, m_mode;
    bit m_owner_v;

    always #5 clk_i = ~clk_i;

    status_vector_ctrl #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .push_req_i      (push_req),
        .push_data_i     (push_data),
        .push_ack_o      (push_ack),
        .set_req_i       (set_req),
        .set_data_i      (set_data),
        .set_ack_o       (set_ack),
        .pull_req_i      (pull_req),
        .pull_ack_o      (pull_ack),
        .drain_i         (drain),
        .drain_done_o    (drain_done),
        .count_o         (count),
        .svv_push_o      (svv_push),
        .svv_pull_o      (svv_pull),
        .svv_set_o       (svv_set),
        .svv_value_o     (svv_value),
        .svv_set_value_o (svv_set_value)
`ifdef STATUS_VECTOR_CTRL_CHECK_EN
        ,
        .svv_valid_i     (svv_valid),
        .svv_full_i      (svv_full),
        .mismatch_o      (mismatch)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_count_d1 = 0; m_ptr = 0; m_owner = 0; m_mode = 0; m_owner_v = 0;
    endtask

    task automatic rand_data();
        push_data = {$urandom, $urandom};
        set_data  = {$urandom, $urandom};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push_ack"}, push_ack, 0);
        check({tag, "_set_ack"}, set_ack, 0);
        check({tag, "_pull_ack"}, pull_ack, 0);
        check({tag, "_drain_done"}, drain_done, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_svv_push"}, svv_push, 0);
        check({tag, "_svv_pull"}, svv_pull, 0);
        check({tag, "_svv_set"}, svv_set, 0);
        check({tag, "_svv_value"}, svv_value, 0);
        check({tag, "_svv_set_value"}, svv_set_value, 0);
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic step();
        int w;
        bit e_pull, e_set;
        logic [NUM_REQ-1:0] e_push_ack, e_set_ack;
        logic [WIDTH-1:0] e_val, e_set_val;
        int old_count;
        #1;
        e_pull = pull_req && (m_count > 0);
        w = -1;
        if (m_mode == 0 && (m_count < DEPTH || e_pull)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int r;
                r = (m_ptr + k) % NUM_REQ;
                if (w < 0 && push_req[r]) w = r;
            end
        end
        e_push_ack = (w >= 0) ? NUM_REQ'(1 << w) : '0;
        e_set = m_owner_v && set_req[m_owner] && (w < 0) && (m_count > 0)
                && !(e_pull && m_count == 1);
        e_set_ack = e_set ? NUM_REQ'(1 << m_owner) : '0;
        e_val     = (w >= 0) ? push_data[w*WIDTH +: WIDTH] : '0;
        e_set_val = set_data[m_owner*WIDTH +: WIDTH];

        check("push_ack", push_ack, e_push_ack);
        check("set_ack", set_ack, e_set_ack);
        check("pull_ack", pull_ack, e_pull);
        check("count", count, m_count);
        check("drain_done", drain_done, m_mode == 2);

        @(posedge clk_i);
        old_count = m_count;
        if (w >= 0) begin
            if (!e_pull) m_count++;
            m_ptr     = (w + 1) % NUM_REQ;
            m_owner   = w;
            m_owner_v = 1;
        end else if (e_pull) begin
            m_count--;
            if (m_count == 0) m_owner_v = 0;
        end
        case (m_mode)
            0: if (drain) m_mode = 1;
            1: if (!drain) m_mode = 0; else if (old_count == 0) m_mode = 2;
            default: if (!drain) m_mode = 0;
        endcase
        m_count_d1 = old_count;

        @(negedge clk_i);
`ifdef STATUS_VECTOR_CTRL_CHECK_EN
        svv_valid = (m_count_d1 > 0);
        svv_full  = (m_count_d1 == DEPTH);
`endif
        check("svv_push", svv_push, w >= 0);
        check("svv_pull", svv_pull, e_pull);
        check("svv_set", svv_set, e_set);
        if (w >= 0) check("svv_value", svv_value, e_val);
        if (e_set) check("svv_set_value", svv_set_value, e_set_val);
    endtask

    initial begin
        rst_i = 1'b1;
        push_req = '0; set_req = '0; pull_req = 1'b0; drain = 1'b0;
        push_data = '0; set_data = '0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Round-robin rotation with a consumer pulling every cycle.
        push_req = 4'b1111; pull_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
        end
        check("rotate_count", count, 1);

        // Fill to full, then full-with-no-pull and full-with-pull.
        pull_req = 1'b0;
        for (int i = 0; i < 200 && m_count < DEPTH; i++) begin
            push_req = NUM_REQ'($urandom_range(1, 15));
            rand_data();
            step();
        end
        check("fill_count", count, DEPTH);
        push_req = 4'b1111;
        step();
        pull_req = 1'b1;
        step();
        check("full_pushpull_count", count, DEPTH);

        // Empty out, pull on empty, then a single push followed by pulls.
        push_req = '0;
        for (int i = 0; i < 100 && m_count > 0; i++) step();
        step();
        push_req = 4'b0001;
        step();
        push_req = '0;
        step();
        check("empty_again", count, 0);

        // Owner-only set, non-owner set, set colliding with a push.
        pull_req = 1'b0;
        push_req = 4'b0100; push_data[2*WIDTH +: WIDTH] = 8'hA5;
        step();
        push_req = '0; set_req = 4'b0100; set_data[2*WIDTH +: WIDTH] = 8'h3C;
        step();
        check("set_value_3c", svv_set_value, 8'h3C);
        set_req = 4'b0010;
        step(); step();
        set_req = 4'b0100; push_req = 4'b0001;
        step();
        push_req = '0;
        step();
        set_req = '0;

        // Random traffic including drain toggles.
        for (int i = 0; i < 400; i++) begin
            push_req = NUM_REQ'($urandom);
            set_req  = NUM_REQ'($urandom);
            pull_req = 1'($urandom);
            if ($urandom_range(0, 19) == 0) drain = ~drain;
            rand_data();
            step();
        end

        // Drain with three entries outstanding.
        drain = 1'b0; set_req = '0; push_req = '0; pull_req = 1'b1;
        for (int i = 0; i < 100 && (m_count > 0 || m_mode != 0); i++) step();
        pull_req = 1'b0; push_req = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        check("pre_drain_count", count, 3);
        drain = 1'b1; push_req = '0;
        step();
        push_req = 4'b1111;
        step();
        pull_req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("drain_done_high", drain_done, 1);
        drain = 1'b0; pull_req = 1'b0;
        step(); step();
        check("push_resumed_count", count, 1);

        // Asynchronous reset with five entries and requests pending.
        push_req = 4'b1111;
        for (int i = 0; i < 200 && m_count != 5; i++) begin
            push_req = (m_count < 5) ? 4'b1111 : 4'b0000;
            pull_req = (m_count > 5);
            step();
        end
        check("pre_reset_count", count, 5);
        push_req = 4'b1111; set_req = 4'b1111; pull_req = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        pull_req = 1'b0; set_req = '0;
        step();
        check("post_reset_owner0", svv_value, push_data[0 +: WIDTH]);
        step();

`ifdef STATUS_VECTOR_CTRL_CHECK_EN
        check("mismatch", mismatch, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
